// File: rtl/dump_window_pkg.sv
// Shared definitions for the dump window controller: trigger mode codes, channel
// state encoding and the mode -> entry-state mapping used on reset and on config writes.
package dump_window_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_IMM   = 2'd1;
  localparam logic [1:0] MODE_FRAME = 2'd2;
  localparam logic [1:0] MODE_DL    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } chan_state_e;

  // State a channel enters when (re)configured with the given mode.
  function automatic chan_state_e entry_state(input logic [1:0] mode);
    case (mode)
      MODE_OFF: return IDLE;
      MODE_IMM: return ACTIVE;
      default:  return ARMED;
    endcase
  endfunction

endpackage

// File: rtl/dump_window_chan.sv
// One dump channel: configuration registers, IDLE/ARMED/ACTIVE/DONE state machine and
// the remaining-frames counter.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   vs_fall, dl_fall    single-cycle frame-end / download-end events
//   frame_cnt           frame counter value before this cycle's increment
//   cfg_sel             load cfg_* into this channel (wins over any trigger)
//   cfg_mode/start/len  configuration bus
//   dump_on, done       registered window-active / window-finished flags
module dump_window_chan
  import dump_window_pkg::*;
#(
  parameter int unsigned FW        = 32,
  parameter int unsigned DEF_MODE  = 0,
  parameter int unsigned DEF_START = 0,
  parameter int unsigned DEF_LEN   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs_fall,
  input  logic          dl_fall,
  input  logic [FW-1:0] frame_cnt,
  input  logic          cfg_sel,
  input  logic [1:0]    cfg_mode,
  input  logic [FW-1:0] cfg_start,
  input  logic [FW-1:0] cfg_len,
  output logic          dump_on,
  output logic          done
);

  localparam chan_state_e RstState = entry_state(2'(DEF_MODE));

  chan_state_e   state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] start_q, start_d;
  logic [FW-1:0] len_q, len_d;
  logic [FW-1:0] rem_q, rem_d;
  logic          dump_on_q, done_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = start_q;
    len_d   = len_q;
    rem_d   = rem_q;
    if (cfg_sel) begin
      // A config write discards any trigger arriving in the same cycle.
      mode_d  = cfg_mode;
      start_d = cfg_start;
      len_d   = cfg_len;
      rem_d   = cfg_len;
      state_d = entry_state(cfg_mode);
    end else begin
      case (state_q)
        ARMED: begin
          if ((mode_q == MODE_FRAME && vs_fall && frame_cnt == start_q) ||
              (mode_q == MODE_DL && dl_fall)) begin
            state_d = ACTIVE;
            rem_d   = len_q;
          end
        end
        ACTIVE: begin
          // len == 0 means the window never closes.
          if (vs_fall && len_q != '0) begin
            if (rem_q == FW'(1)) state_d = DONE;
            else                 rem_d   = rem_q - FW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RstState;
      mode_q    <= 2'(DEF_MODE);
      start_q   <= FW'(DEF_START);
      len_q     <= FW'(DEF_LEN);
      rem_q     <= FW'(DEF_LEN);
      dump_on_q <= (RstState == ACTIVE);
      done_q    <= (RstState == DONE);
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      dump_on_q <= (state_d == ACTIVE);
      done_q    <= (state_d == DONE);
    end
  end

  assign dump_on = dump_on_q;
  assign done    = done_q;

endmodule

// File: rtl/dump_window_ctrl.sv
// Multi-channel dump window generator. Detects falling edges of vsync and download,
// counts frames, suppresses download-end triggers for HOLDOFF cycles after reset, and
// runs one dump_window_chan per channel.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   vs, dwnld            vertical sync and ROM-download activity (synchronous to clk)
//   cfg_we/cfg_ch        write strobe and target channel for cfg_mode/start/len
//   frame_cnt            frames seen since reset (wraps)
//   dump_on, done        per-channel window active / finished
//   dump_any             OR of dump_on
module dump_window_ctrl
  import dump_window_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned FW         = 32,
  parameter int unsigned HOLDOFF    = 20000,
  parameter int unsigned DEF_MODE0  = 0,
  parameter int unsigned DEF_START0 = 0,
  parameter int unsigned DEF_LEN0   = 0,
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vs,
  input  logic           dwnld,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [FW-1:0]  cfg_start,
  input  logic [FW-1:0]  cfg_len,
  output logic [FW-1:0]  frame_cnt,
  output logic [NCH-1:0] dump_on,
  output logic [NCH-1:0] done,
  output logic           dump_any
);

  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  logic          vs_s, vs_l, dwnld_s, dwnld_l;
  logic          vs_fall_q, dl_fall_q;
  logic [FW-1:0] frame_cnt_q;
  logic [HW-1:0] hold_cnt_q;
  logic          holdoff_done_q;
  logic [NCH-1:0] cfg_sel;

  // Inputs are sampled, delayed once more, and the edge event itself is registered, so a
  // fall first sampled at edge k updates the frame counter and channels at edge k+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_s      <= 1'b0;
      vs_l      <= 1'b0;
      dwnld_s   <= 1'b0;
      dwnld_l   <= 1'b0;
      vs_fall_q <= 1'b0;
      dl_fall_q <= 1'b0;
    end else begin
      vs_s      <= vs;
      vs_l      <= vs_s;
      dwnld_s   <= dwnld;
      dwnld_l   <= dwnld_s;
      vs_fall_q <= vs_l & ~vs_s;
      dl_fall_q <= dwnld_l & ~dwnld_s & holdoff_done_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (vs_fall_q) begin
      frame_cnt_q <= frame_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q     <= '0;
      holdoff_done_q <= (HOLDOFF == 0);
    end else if (!holdoff_done_q) begin
      if (hold_cnt_q == HW'(HOLDOFF - 1)) holdoff_done_q <= 1'b1;
      else                                hold_cnt_q     <= hold_cnt_q + HW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign cfg_sel[i] = cfg_we && (cfg_ch == CW'(i));

    // Only channel 0 has a configurable power-on behaviour.
    dump_window_chan #(
      .FW       (FW),
      .DEF_MODE ((i == 0) ? DEF_MODE0  : 32'd0),
      .DEF_START((i == 0) ? DEF_START0 : 32'd0),
      .DEF_LEN  ((i == 0) ? DEF_LEN0   : 32'd0)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .vs_fall  (vs_fall_q),
      .dl_fall  (dl_fall_q),
      .frame_cnt(frame_cnt_q),
      .cfg_sel  (cfg_sel[i]),
      .cfg_mode (cfg_mode),
      .cfg_start(cfg_start),
      .cfg_len  (cfg_len),
      .dump_on  (dump_on[i]),
      .done     (done[i])
    );
  end

  assign frame_cnt = frame_cnt_q;
  assign dump_any  = |dump_on;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Directed bench for dump_window_ctrl (NCH=4, FW=4, HOLDOFF=100, channel 0 IMMEDIATE).
module tb_dump_window_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic       dwnld = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_start = '0;
  logic [3:0] cfg_len = '0;
  logic [3:0] frame_cnt;
  logic [3:0] dump_on;
  logic [3:0] done;
  logic       dump_any;

  int n_vec = 0;
  int n_err = 0;

  dump_window_ctrl #(
    .NCH       (4),
    .FW        (4),
    .HOLDOFF   (100),
    .DEF_MODE0 (1),
    .DEF_START0(0),
    .DEF_LEN0  (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vs       (vs),
    .dwnld    (dwnld),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_start(cfg_start),
    .cfg_len  (cfg_len),
    .frame_cnt(frame_cnt),
    .dump_on  (dump_on),
    .done     (done),
    .dump_any (dump_any)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] start,
                     input logic [3:0] len);
    cfg_ch = ch; cfg_mode = mode; cfg_start = start; cfg_len = len; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Returns just after the edge at which frame_cnt and the channels react.
  task automatic vs_pulse;
    vs = 1'b1; tick();
    vs = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (dump_on !== 4'b0001) begin n_err++;
      $display("FAIL reset_dump_on: got %b want 0001", dump_on); end
    n_vec++; if (done !== 4'b0000) begin n_err++;
      $display("FAIL reset_done: got %b want 0000", done); end
    n_vec++; if (frame_cnt !== 4'd0) begin n_err++;
      $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_vec++; if (dump_any !== 1'b1) begin n_err++;
      $display("FAIL reset_dump_any: got %b want 1", dump_any); end
    rst = 1'b0;
  endtask

  task automatic test_download;
    cfg(2'd2, 2'd3, 4'd0, 4'd0);                  // cycle 1
    dwnld = 1'b1; repeat (45) tick();
    dwnld = 1'b0; repeat (4) tick();              // fall near cycle 50, inside holdoff
    n_vec++; if (dump_on[2] !== 1'b0) begin n_err++;
      $display("FAIL dl_holdoff: got dump_on[2]=%b want 0", dump_on[2]); end
    dwnld = 1'b1; repeat (245) tick();
    dwnld = 1'b0; tick(); tick();
    n_vec++; if (dump_on[2] !== 1'b0) begin n_err++;
      $display("FAIL dl_early: got dump_on[2]=%b want 0", dump_on[2]); end
    tick();
    n_vec++; if (dump_on[2] !== 1'b1) begin n_err++;
      $display("FAIL dl_open: got dump_on[2]=%b want 1", dump_on[2]); end
    n_vec++; if (done[2] !== 1'b0) begin n_err++;
      $display("FAIL dl_done: got done[2]=%b want 0", done[2]); end
  endtask

  task automatic test_frame_window;
    cfg(2'd1, 2'd2, 4'd5, 4'd3);
    for (int p = 1; p <= 10; p++) begin
      logic exp_on, exp_done;
      vs_pulse();
      exp_on   = (p >= 6) && (p <= 8);
      exp_done = (p >= 9);
      n_vec++; if (frame_cnt !== 4'(p)) begin n_err++;
        $display("FAIL frame_cnt pulse %0d: got %0d want %0d", p, frame_cnt, p); end
      n_vec++; if (dump_on[1] !== exp_on) begin n_err++;
        $display("FAIL frame_on pulse %0d: got %b want %b", p, dump_on[1], exp_on); end
      n_vec++; if (done[1] !== exp_done) begin n_err++;
        $display("FAIL frame_done pulse %0d: got %b want %b", p, done[1], exp_done); end
    end
  endtask

  task automatic test_rearm_collision;
    cfg(2'd1, 2'd2, 4'd10, 4'd1);
    vs_pulse();
    n_vec++; if (dump_on[1] !== 1'b1) begin n_err++;
      $display("FAIL rearm_pre_active: got %b want 1", dump_on[1]); end
    // This vs_fall would close the window, but a config write lands on the same edge.
    vs = 1'b1; tick();
    vs = 1'b0; tick(); tick();
    cfg(2'd1, 2'd2, 4'd4, 4'd1);                  // start 20 mod 16
    n_vec++; if (frame_cnt !== 4'd12) begin n_err++;
      $display("FAIL rearm_frame_cnt: got %0d want 12", frame_cnt); end
    n_vec++; if (dump_on[1] !== 1'b0) begin n_err++;
      $display("FAIL rearm_on: got %b want 0", dump_on[1]); end
    n_vec++; if (done[1] !== 1'b0) begin n_err++;
      $display("FAIL rearm_done: got %b want 0", done[1]); end
  endtask

  task automatic test_wrap;
    logic [3:0] exp_fc [7];
    logic       exp_on3 [7];
    logic       exp_dn3 [7];
    logic       exp_on1 [7];
    exp_fc  = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    exp_on3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_dn3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_on1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vs_pulse(); vs_pulse();
    n_vec++; if (frame_cnt !== 4'd14) begin n_err++;
      $display("FAIL wrap_pre_cnt: got %0d want 14", frame_cnt); end
    cfg(2'd3, 2'd2, 4'd2, 4'd2);
    for (int p = 0; p < 7; p++) begin
      vs_pulse();
      n_vec++; if (frame_cnt !== exp_fc[p]) begin n_err++;
        $display("FAIL wrap_cnt step %0d: got %0d want %0d", p, frame_cnt, exp_fc[p]); end
      n_vec++; if (dump_on[3] !== exp_on3[p]) begin n_err++;
        $display("FAIL wrap_on3 step %0d: got %b want %b", p, dump_on[3], exp_on3[p]); end
      n_vec++; if (done[3] !== exp_dn3[p]) begin n_err++;
        $display("FAIL wrap_done3 step %0d: got %b want %b", p, done[3], exp_dn3[p]); end
      n_vec++; if (dump_on[1] !== exp_on1[p]) begin n_err++;
        $display("FAIL wrap_on1 step %0d: got %b want %b", p, dump_on[1], exp_on1[p]); end
    end
  endtask

  task automatic test_reset_active;
    rst = 1'b1;
    tick();
    n_vec++; if (dump_on !== 4'b0001) begin n_err++;
      $display("FAIL rst_active_on: got %b want 0001", dump_on); end
    n_vec++; if (done !== 4'b0000) begin n_err++;
      $display("FAIL rst_active_done: got %b want 0000", done); end
    n_vec++; if (frame_cnt !== 4'd0) begin n_err++;
      $display("FAIL rst_active_cnt: got %0d want 0", frame_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_cross_channel;
    cfg(2'd1, 2'd2, 4'd0, 4'd0);
    vs = 1'b1; tick();
    vs = 1'b0; tick(); tick();
    cfg(2'd3, 2'd1, 4'd0, 4'd0);                  // same edge as ch1 trigger
    n_vec++; if (dump_on !== 4'b1011) begin n_err++;
      $display("FAIL cross_on: got %b want 1011", dump_on); end
    n_vec++; if (frame_cnt !== 4'd1) begin n_err++;
      $display("FAIL cross_cnt: got %0d want 1", frame_cnt); end
    cfg(2'd3, 2'd0, 4'd0, 4'd0);
    n_vec++; if (dump_on !== 4'b0011) begin n_err++;
      $display("FAIL off_ch3: got %b want 0011", dump_on); end
    cfg(2'd0, 2'd0, 4'd0, 4'd0);
    n_vec++; if (dump_on !== 4'b0010 || dump_any !== 1'b1) begin n_err++;
      $display("FAIL off_ch0: got %b/%b want 0010/1", dump_on, dump_any); end
    cfg(2'd1, 2'd0, 4'd0, 4'd0);
    n_vec++; if (dump_on !== 4'b0000 || dump_any !== 1'b0) begin n_err++;
      $display("FAIL off_all: got %b/%b want 0000/0", dump_on, dump_any); end
  endtask

  initial begin
    test_reset();
    test_download();
    test_frame_window();
    test_rearm_collision();
    test_wrap();
    test_reset_active();
    test_cross_channel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
